// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the I/D memory bus arbiter: requester identity,
// transaction FSM states and the core's address/data word typedefs.
package mem_bus_arbiter_pkg;

   typedef logic [31:0] Addr;
   typedef logic [31:0] UIntX;

   typedef enum logic [0:0] {
      ARB_I = 1'b0,
      ARB_D = 1'b1
   } ArbOwner;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_REQ  = 2'd1,
      ARB_RESP = 2'd2
   } ArbState;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch (I) and data (D) requesters plus the
// starvation counter that forces an I grant after STARVE_LIMIT D grants.
module mem_arb_pick
   import mem_bus_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
   input  logic             idle_i,
   input  logic             i_valid_i,
   input  logic             d_valid_i,
   input  logic [CNT_W-1:0] cnt_i,
   output logic             grant_valid_o,
   output ArbOwner          grant_owner_o,
   output logic [CNT_W-1:0] cnt_nxt_o
);

   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

   logic i_starved;

   // D wins by default; a starved, still-waiting I overrides it
   always_comb begin
      i_starved     = i_valid_i && (cnt_i == LIMIT_C);
      grant_valid_o = idle_i && (i_valid_i || d_valid_i);
      if (d_valid_i && !i_starved) begin
         grant_owner_o = ARB_D;
      end else begin
         grant_owner_o = ARB_I;
      end

      // Count only D grants that passed over a waiting I; any idle cycle
      // without an I request, or an I grant, restarts the count.
      cnt_nxt_o = cnt_i;
      if (idle_i) begin
         if (!i_valid_i || (grant_owner_o == ARB_I)) begin
            cnt_nxt_o = '0;
         end else if (cnt_i != LIMIT_C) begin
            cnt_nxt_o = cnt_i + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch (I) and data (D).
// One transaction in flight: IDLE accepts, REQ presents it to memory,
// RESP routes the single response back to its owner. A fetch flush while
// an I transaction is in flight swallows its response.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_req_valid,
   output logic                i_req_ready,
   input  logic [ADDR_W-1:0]   i_req_addr,
   input  logic                i_flush,
   output logic                i_resp_valid,
   output logic [DATA_W-1:0]   i_resp_rdata,
   input  logic                d_req_valid,
   output logic                d_req_ready,
   input  logic [ADDR_W-1:0]   d_req_addr,
   input  logic                d_req_wen,
   input  logic [DATA_W-1:0]   d_req_wdata,
   input  logic [DATA_W/8-1:0] d_req_wmask,
   output logic                d_resp_valid,
   output logic [DATA_W-1:0]   d_resp_rdata,
   output logic                m_req_valid,
   input  logic                m_req_ready,
   output logic [ADDR_W-1:0]   m_req_addr,
   output logic                m_req_wen,
   output logic [DATA_W-1:0]   m_req_wdata,
   output logic [DATA_W/8-1:0] m_req_wmask,
   input  logic                m_resp_valid,
   input  logic [DATA_W-1:0]   m_resp_rdata
);

   localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
   localparam int MASK_W = DATA_W / 8;

   ArbState             state_q, state_d;
   ArbOwner             owner_q;
   logic                drop_q;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q;
   logic                wen_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [MASK_W-1:0]   wmask_q;

   logic                idle;
   logic                grant_valid;
   ArbOwner             grant_owner;
   logic                flush_hit;
   logic                resp_fire;

   mem_arb_pick #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .CNT_W        (CNT_W)
   ) u_pick (
      .idle_i        (idle),
      .i_valid_i     (i_req_valid),
      .d_valid_i     (d_req_valid),
      .cnt_i         (cnt_q),
      .grant_valid_o (grant_valid),
      .grant_owner_o (grant_owner),
      .cnt_nxt_o     (cnt_d)
   );

   // Handshakes, response routing and next-state for the transaction FSM
   always_comb begin
      // Nothing is accepted or routed while reset is being applied
      idle      = rst_n && (state_q == ARB_IDLE);
      flush_hit = i_flush && (owner_q == ARB_I) &&
                  ((state_q == ARB_REQ) || (state_q == ARB_RESP));
      resp_fire = rst_n && (state_q == ARB_RESP) && m_resp_valid;

      i_req_ready  = grant_valid && (grant_owner == ARB_I);
      d_req_ready  = grant_valid && (grant_owner == ARB_D);

      // A flush in the very cycle of the response still suppresses it
      i_resp_valid = resp_fire && (owner_q == ARB_I) && !(drop_q || flush_hit);
      d_resp_valid = resp_fire && (owner_q == ARB_D);
      i_resp_rdata = m_resp_rdata;
      d_resp_rdata = m_resp_rdata;

      m_req_valid  = (state_q == ARB_REQ);
      m_req_addr   = addr_q;
      m_req_wen    = wen_q;
      m_req_wdata  = wdata_q;
      m_req_wmask  = wmask_q;

      state_d = state_q;
      case (state_q)
         ARB_IDLE: if (grant_valid)  state_d = ARB_REQ;
         ARB_REQ:  if (m_req_ready)  state_d = ARB_RESP;
         ARB_RESP: if (m_resp_valid) state_d = ARB_IDLE;
         default:                    state_d = ARB_IDLE;
      endcase
   end

   // FSM, starvation count, flush-drop flag and the registered memory request
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
         owner_q <= ARB_I;
         drop_q  <= 1'b0;
         cnt_q   <= '0;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (grant_valid) begin
            owner_q <= grant_owner;
            if (grant_owner == ARB_D) begin
               addr_q  <= d_req_addr;
               wen_q   <= d_req_wen;
               wdata_q <= d_req_wdata;
               wmask_q <= d_req_wmask;
            end else begin
               addr_q  <= i_req_addr;
               wen_q   <= 1'b0;
               wdata_q <= '0;
               wmask_q <= '0;
            end
         end
         if (resp_fire) begin
            drop_q <= 1'b0;
         end else if (flush_hit) begin
            drop_q <= 1'b1;
         end
      end
   end

`ifndef SYNTHESIS
   // Memory may only answer a transaction that is waiting for it; the cycle
   // right after reset is tolerated since an aborted transaction may still
   // get its late response then.
   a_resp_only_in_resp: assert property (@(posedge clk) disable iff (!rst_n)
      m_resp_valid |-> ((state_q == ARB_RESP) || !$past(rst_n)));
`endif

endmodule
